// File: rtl/cp0_int_ctrl_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions,
// exception codes and device address map.
package cp0_int_ctrl_pkg;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int SR_IM_LO = 10;
   localparam int SR_IM_HI = 15;

   localparam int CA_EXC_LO = 2;
   localparam int CA_EXC_HI = 6;
   localparam int CA_IP_LO  = 10;
   localparam int CA_IP_HI  = 15;
   localparam int CA_BD     = 31;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam logic [31:0] DEV_TIMER0_BASE = 32'h0000_7F00;
   localparam logic [31:0] DEV_TIMER1_BASE = 32'h0000_7F10;

   localparam logic [31:0] DEF_PRID       = 32'h0000_B0A7;
   localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;

endpackage

// File: rtl/cp0_int_ctrl_if.sv
// Commit-stage <-> CP0 bundle: mfc0/mtc0 access, exception inputs,
// and the flush/redirect outputs.
interface cp0_int_ctrl_if;

   logic [4:0]  rd_addr;
   logic [4:0]  wr_addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] pc_in;
   logic        bd_in;
   logic [4:0]  exc_code;
   logic        eret;
   logic [5:0]  hw_int;
   logic [31:0] rd_data;
   logic [31:0] epc_out;
   logic        req;
   logic [31:0] exc_entry_pc;

   modport master (
      output rd_addr, wr_addr, wr_en, wr_data,
      output pc_in, bd_in, exc_code, eret, hw_int,
      input  rd_data, epc_out, req, exc_entry_pc
   );

   modport slave (
      input  rd_addr, wr_addr, wr_en, wr_data,
      input  pc_in, bd_in, exc_code, eret, hw_int,
      output rd_data, epc_out, req, exc_entry_pc
   );

endinterface

// File: rtl/cp0_int_ctrl_req_logic.sv
// Combinational request decision: interrupt/exception pending and
// the ExcCode to latch, with interrupts ahead of exceptions.
module cp0_int_ctrl_req_logic
   import cp0_int_ctrl_pkg::*;
(
   input  logic [5:0] i_hw_int,
   input  logic [5:0] i_im,
   input  logic       i_ie,
   input  logic       i_exl,
   input  logic [4:0] i_exc_code,
   output logic       o_int_pend,
   output logic       o_exc_pend,
   output logic [4:0] o_exc_sel
);

   assign o_int_pend = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
   assign o_exc_pend = (i_exc_code != EXC_INT) & ~i_exl;
   assign o_exc_sel  = o_int_pend ? EXC_INT : i_exc_code;

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 exception/interrupt controller: SR, Cause, EPC, PRId and the
// same-cycle flush request for the commit stage.
module cp0_int_ctrl
   import cp0_int_ctrl_pkg::*;
#(
   parameter logic [31:0] PRID       = DEF_PRID,
   parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC
) (
   input logic         clk,
   input logic         reset,
   cp0_int_ctrl_if.slave bus
);

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic        r_bd;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc;
   logic [31:0] r_epc;

   logic        w_int_pend;
   logic        w_exc_pend;
   logic        w_req;
   logic [4:0]  w_exc_sel;
   logic [31:0] w_epc_next;
   logic [31:0] w_sr;
   logic [31:0] w_cause;
   logic        w_wr_sr;
   logic        w_wr_epc;

   cp0_int_ctrl_req_logic u_req (
      .i_hw_int   (bus.hw_int),
      .i_im       (r_im),
      .i_ie       (r_ie),
      .i_exl      (r_exl),
      .i_exc_code (bus.exc_code),
      .o_int_pend (w_int_pend),
      .o_exc_pend (w_exc_pend),
      .o_exc_sel  (w_exc_sel)
   );

   assign w_req      = w_int_pend | w_exc_pend;
   assign w_epc_next = bus.bd_in ? (bus.pc_in - 32'd4) : bus.pc_in;
   assign w_wr_sr    = bus.wr_en & (bus.wr_addr == CP0_SR);
   assign w_wr_epc   = bus.wr_en & (bus.wr_addr == CP0_EPC);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_im  <= '0;
         r_exl <= 1'b0;
         r_ie  <= 1'b0;
         r_bd  <= 1'b0;
         r_ip  <= '0;
         r_exc <= '0;
         r_epc <= '0;
      end else begin
         r_ip <= bus.hw_int;
         if (w_req) begin
            r_exl <= 1'b1;
            r_bd  <= bus.bd_in;
            r_epc <= {w_epc_next[31:2], 2'b00};
            r_exc <= w_exc_sel;
         end else begin
            if (w_wr_sr) begin
               r_im  <= bus.wr_data[SR_IM_HI:SR_IM_LO];
               r_exl <= bus.wr_data[SR_EXL];
               r_ie  <= bus.wr_data[SR_IE];
            end
            if (w_wr_epc)
               r_epc <= {bus.wr_data[31:2], 2'b00};
            // eret is ordered after an SR write in the same cycle
            if (bus.eret)
               r_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      w_sr = '0;
      w_sr[SR_IM_HI:SR_IM_LO] = r_im;
      w_sr[SR_EXL] = r_exl;
      w_sr[SR_IE]  = r_ie;
   end

   always_comb begin
      w_cause = '0;
      w_cause[CA_BD] = r_bd;
      w_cause[CA_IP_HI:CA_IP_LO] = r_ip;
      w_cause[CA_EXC_HI:CA_EXC_LO] = r_exc;
   end

   always_comb begin
      bus.rd_data = '0;
      case (bus.rd_addr)
         CP0_SR:    bus.rd_data = w_sr;
         CP0_CAUSE: bus.rd_data = w_cause;
         CP0_EPC:   bus.rd_data = r_epc;
         CP0_PRID:  bus.rd_data = PRID;
         default:   bus.rd_data = '0;
      endcase
   end

   assign bus.epc_out      = r_epc;
   assign bus.req          = w_req;
   assign bus.exc_entry_pc = w_req ? HANDLER_PC : 32'h0;

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: per-cycle vector table plus a
// reset-during-handler sequence.
module tb_cp0_int_ctrl;
   import cp0_int_ctrl_pkg::*;

   localparam logic [31:0] P_ID = 32'h0000_B0A7;
   localparam logic [31:0] H_PC = 32'h0000_4180;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   cp0_int_ctrl_if bus ();

   cp0_int_ctrl #(.PRID(P_ID), .HANDLER_PC(H_PC)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [31:0] pc;
      logic        bd;
      logic [4:0]  exc;
      logic        eret;
      logic [5:0]  hw;
      logic        e_req;
      logic [31:0] e_rd;
      logic [31:0] e_epc;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      logic [4:0] rd, logic we, logic [4:0] wa, logic [31:0] wd,
      logic [31:0] pc, logic bd, logic [4:0] exc, logic eret,
      logic [5:0] hw, logic e_req, logic [31:0] e_rd,
      logic [31:0] e_epc);
      vec_t v;
      v.rd = rd; v.we = we; v.wa = wa; v.wd = wd;
      v.pc = pc; v.bd = bd; v.exc = exc; v.eret = eret;
      v.hw = hw; v.e_req = e_req; v.e_rd = e_rd; v.e_epc = e_epc;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      bus.rd_addr  = v.rd;
      bus.wr_en    = v.we;
      bus.wr_addr  = v.wa;
      bus.wr_data  = v.wd;
      bus.pc_in    = v.pc;
      bus.bd_in    = v.bd;
      bus.exc_code = v.exc;
      bus.eret     = v.eret;
      bus.hw_int   = v.hw;
   endtask

   task automatic check_outs(string tag, vec_t v);
      chk({tag, ".req"}, {31'b0, bus.req}, {31'b0, v.e_req});
      chk({tag, ".rd"}, bus.rd_data, v.e_rd);
      chk({tag, ".epc"}, bus.epc_out, v.e_epc);
      chk({tag, ".entry"}, bus.exc_entry_pc, v.e_req ? H_PC : 32'h0);
   endtask

   initial begin
      vec_t v;
      checks = 0;
      failures = 0;
      reset = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      //       rd  we wa  wd            pc            bd exc eret hw     req rd            epc
      vq.push_back(mk(13, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0,        32'h0));
      vq.push_back(mk(14, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0,        32'h0));
      vq.push_back(mk(15, 0, 0, 0,            0,            0, 0,  0, 6'h3F, 0, P_ID,         32'h0));
      vq.push_back(mk(13, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0000_FC00, 32'h0));
      vq.push_back(mk(12, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0,        32'h0));
      vq.push_back(mk(12, 1, 12, 32'h0000_0401, 0,          0, 0,  0, 6'h00, 0, 32'h0,        32'h0));
      vq.push_back(mk(12, 0, 0, 0,            32'h3008,     0, 0,  0, 6'h01, 1, 32'h0000_0401, 32'h0));
      vq.push_back(mk(13, 0, 0, 0,            0,            0, 0,  0, 6'h01, 0, 32'h0000_0400, 32'h3008));
      vq.push_back(mk(12, 0, 0, 0,            0,            0, 0,  1, 6'h01, 0, 32'h0000_0403, 32'h3008));
      vq.push_back(mk(12, 0, 0, 0,            32'h3100,     0, 0,  0, 6'h01, 1, 32'h0000_0401, 32'h3008));
      vq.push_back(mk(14, 0, 0, 0,            0,            0, 0,  1, 6'h00, 0, 32'h0000_3100, 32'h3100));
      vq.push_back(mk(12, 1, 12, 32'h0000_0001, 0,          0, 0,  0, 6'h00, 0, 32'h0000_0401, 32'h3100));
      vq.push_back(mk(13, 0, 0, 0,            32'h3010,     1, EXC_OV, 0, 6'h3F, 1, 32'h0, 32'h3100));
      vq.push_back(mk(13, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h8000_FC30, 32'h300C));
      vq.push_back(mk(14, 0, 0, 0,            0,            0, EXC_RI, 0, 6'h00, 0, 32'h300C, 32'h300C));
      vq.push_back(mk(12, 0, 0, 0,            0,            0, 0,  1, 6'h00, 0, 32'h0000_0003, 32'h300C));
      vq.push_back(mk(12, 1, 12, 32'h0000_1001, 0,          0, 0,  0, 6'h00, 0, 32'h0000_0001, 32'h300C));
      vq.push_back(mk(14, 1, 14, 32'hDEAD_0000, 32'h3020,   0, EXC_RI, 0, 6'h04, 1, 32'h300C, 32'h300C));
      vq.push_back(mk(13, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0000_1000, 32'h3020));
      vq.push_back(mk(14, 0, 0, 0,            0,            0, 0,  1, 6'h00, 0, 32'h3020,     32'h3020));
      vq.push_back(mk(14, 1, 14, 32'h0000_3017, 0,          0, 0,  0, 6'h00, 0, 32'h3020,     32'h3020));
      vq.push_back(mk(14, 1, 13, 32'hFFFF_FFFF, 0,          0, 0,  0, 6'h00, 0, 32'h3014,     32'h3014));
      vq.push_back(mk(13, 1, 15, 32'h0,        0,           0, 0,  0, 6'h00, 0, 32'h0,        32'h3014));
      vq.push_back(mk(15, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, P_ID,         32'h3014));
      vq.push_back(mk(7,  0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0,        32'h3014));
      vq.push_back(mk(12, 1, 12, 32'h0000_1003, 0,          0, 0,  1, 6'h00, 0, 32'h0000_1001, 32'h3014));
      vq.push_back(mk(12, 0, 0, 0,            0,            0, 0,  0, 6'h00, 0, 32'h0000_1001, 32'h3014));

      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i]);
         #1;
         check_outs($sformatf("v%0d", i), vq[i]);
         @(negedge clk);
      end

      // Reset taken while inside a handler with the IRQ line held high.
      v = mk(12, 0, 0, 0, 32'h3200, 0, 0, 0, 6'h04, 1, 32'h0000_1001, 32'h3014);
      drive(v);
      #1;
      check_outs("rst.take", v);
      @(negedge clk);
      v = mk(12, 0, 0, 0, 0, 0, 0, 0, 6'h04, 0, 32'h0000_1003, 32'h3200);
      drive(v);
      #1;
      check_outs("rst.inh", v);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      v = mk(12, 0, 0, 0, 0, 0, 0, 0, 6'h04, 0, 32'h0, 32'h0);
      drive(v);
      #1;
      check_outs("rst.after", v);
      @(negedge clk);
      v = mk(13, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0, 32'h0000_1000, 32'h0);
      drive(v);
      #1;
      check_outs("rst.cause", v);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
